fitness_scheduler: RTL
======================

# fitness_scheduler

Population-level sequencer that drives the per-chromosome fitness calculator of the genetic-algorithm engine. On a start request it walks the population memory, presents each chromosome to the calculator, issues the calculator's `start` pulse, and waits for `done`. It then writes each returned fitness into the fitness store and tracks the best (lowest-mismatch) individual, signalling completion of the whole generation.

## Interface
- `GENOME_LENGTH`, 28: bytes per chromosome; must match the calculator.
- `POP_SIZE`, 16: individuals per generation, 2..256.
- `IDX_W`, `$clog2(POP_SIZE)`: index width.
- `TIMEOUT_CYCLES`, 64: watchdog limit; used only with the macro below.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `eval_start`  in  1  one-cycle request to evaluate the generation. Ignored while `busy`.
- `pop_rd_addr`  out  IDX_W  population memory read address. Data is valid one cycle later.
- `pop_rd_data`  in  8×GENOME_LENGTH  unpacked chromosome from the population memory.
- `calc_start`  out  1  start pulse to the calculator.
- `calc_chromosome`  out  8×GENOME_LENGTH  registered chromosome to the calculator.
- `calc_fitness`  in  5  calculator result.
- `calc_done`  in  1  calculator done. It is sticky until the next start.
- `fit_wr_en`  out  1  fitness store write strobe.
- `fit_wr_addr`  out  IDX_W  fitness store address.
- `fit_wr_data`  out  5  fitness value written.
- `best_idx`  out  IDX_W  index of the best individual.
- `best_fitness`  out  5  fitness of the best individual.
- `busy`  out  1  evaluation in progress.
- `eval_done`  out  1  one-cycle completion pulse.
- `timeout_err`  out  1  sticky watchdog flag. Constant 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, WAIT, STORE, FINISH.
- IDLE:
  - On `eval_start`: idx←0, `best_fitness`←31, `best_idx`←0, `timeout_err`←0, then go to FETCH.
- FETCH: `pop_rd_addr`=idx. Go to LOAD.
- LOAD: `calc_chromosome`←`pop_rd_data`. Go to START.
- START: `calc_start`=1 for exactly this cycle. Go to WAIT.
- WAIT:
  - Stay until `calc_done`=1, then go to STORE.
  - `calc_done` is sampled only in WAIT. The stale high level from the previous evaluation is cleared by the calculator at the end of START.
- STORE:
  - `fit_wr_en`=1, `fit_wr_addr`=idx, `fit_wr_data`=`calc_fitness` for one cycle.
  - If `calc_fitness` < `best_fitness`: update `best_fitness` and `best_idx`. On ties the lower index is kept.
  - If idx==POP_SIZE-1: go to FINISH. Otherwise idx←idx+1 and go to FETCH.
- FINISH: `eval_done`=1 for one cycle. Go to IDLE.
- `calc_chromosome` holds stable from LOAD through the end of WAIT, because the calculator indexes it every cycle.
- `busy`=1 in every state except IDLE.
- `best_idx` and `best_fitness` hold their values after FINISH until the next accepted `eval_start`.
- Fitness values are passed through unmodified. There is no saturation or arithmetic beyond the 5-bit unsigned compare.

## Timing
- Reset values: state IDLE; `calc_chromosome` all 0; `best_fitness`=31; all other outputs 0.
- `rst` mid-evaluation aborts immediately. No further writes occur and no `eval_done` pulse is issued.
- With the companion calculator, `calc_done` rises in the 29th WAIT cycle. Per individual this is 1+1+1+29+1 = 33 cycles.
- Generation latency is POP_SIZE×33+1 cycles from the accepted `eval_start` to `eval_done`; 529 cycles for POP_SIZE=16.
- `eval_start` asserted in the same cycle as FINISH is ignored, because `busy` is still 1.
- Exactly one `fit_wr_en` pulse per individual, at addresses 0..POP_SIZE-1 in ascending order.

## Configuration
- Macro: `FITNESS_SCHED_TIMEOUT_EN`.
- Defined:
  - A WAIT-cycle counter runs. If it reaches TIMEOUT_CYCLES without `calc_done`, the FSM goes to STORE with `fit_wr_data`=31.
  - `timeout_err`←1 (sticky until the next accepted `eval_start`), and evaluation continues with the next index.
- Undefined: WAIT blocks indefinitely, there is no counter, and `timeout_err` is tied to 0.

## Test plan
- Reset release, with POP_SIZE=4 for every scenario:
  - Outputs at reset values: `best_fitness`=31, `busy`=0.
  - Mid-run reset: assert `rst` during WAIT of index 2 → state IDLE, no further `fit_wr_en`, no `eval_done` pulse.
- Population with mismatch counts 5,3,3,9 against the calculator:
  - Writes 5,3,3,9 to addresses 0..3.
  - `best_idx`=1, `best_fitness`=3 (tie keeps the lower index).
  - `eval_done` 133 cycles after `eval_start`.
- Handshake, with a model returning `calc_done` stuck high:
  - `calc_start` is one cycle per individual, exactly 4 pulses.
  - `calc_chromosome` is constant throughout each WAIT.
  - STORE is entered only after `calc_start`.
- `eval_start` while `busy` → ignored: run length, writes and best result are unchanged.
- Back-to-back generations:
  - `eval_start` pulsed the cycle after `eval_done` → second run starts cleanly.
  - `best_fitness` resets to 31 before the updates of the new run.
- With `FITNESS_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=64 and a model that never returns `done` for index 1:
  - `fit_wr_data`=31 at address 1 after 64 WAIT cycles.
  - `timeout_err`=1 and indices 2..3 are still evaluated.

Source files
------------

// File: rtl/fitness_scheduler_if.sv
// Population-memory, fitness-calculator and fitness-store signals of fitness_scheduler.
interface fitness_scheduler_if #(
  parameter int unsigned GENOME_LENGTH = 28,
  parameter int unsigned IDX_W         = 4
);
  logic [IDX_W-1:0] pop_rd_addr;
  logic [7:0]       pop_rd_data     [GENOME_LENGTH];
  logic             calc_start;
  logic [7:0]       calc_chromosome [GENOME_LENGTH];
  logic [4:0]       calc_fitness;
  logic             calc_done;
  logic             fit_wr_en;
  logic [IDX_W-1:0] fit_wr_addr;
  logic [4:0]       fit_wr_data;

  modport master (
    output pop_rd_addr, calc_start, calc_chromosome, fit_wr_en, fit_wr_addr, fit_wr_data,
    input  pop_rd_data, calc_fitness, calc_done
  );

  modport slave (
    input  pop_rd_addr, calc_start, calc_chromosome, fit_wr_en, fit_wr_addr, fit_wr_data,
    output pop_rd_data, calc_fitness, calc_done
  );
endinterface

// File: rtl/fitness_scheduler.sv
// Walks the population through the fitness calculator, stores each result and tracks the best.
// Optional WAIT watchdog: define FITNESS_SCHED_TIMEOUT_EN.
module fitness_scheduler #(
  parameter int unsigned GENOME_LENGTH = 28,
  parameter int unsigned POP_SIZE      = 16,
  parameter int unsigned IDX_W         = $clog2(POP_SIZE)
`ifdef FITNESS_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 eval_start,
  fitness_scheduler_if.master  bus,
  output logic [IDX_W-1:0]     best_idx,
  output logic [4:0]           best_fitness,
  output logic                 busy,
  output logic                 eval_done,
  output logic                 timeout_err
);

  localparam logic [4:0] FIT_WORST = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_STORE, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pop_rd_addr_q, pop_rd_addr_d;
  logic             calc_start_q, calc_start_d;
  logic [7:0]       chrom_q [GENOME_LENGTH];
  logic [7:0]       chrom_d [GENOME_LENGTH];
  logic             fit_wr_en_q, fit_wr_en_d;
  logic [IDX_W-1:0] fit_wr_addr_q, fit_wr_addr_d;
  logic [4:0]       fit_wr_data_q, fit_wr_data_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [4:0]       best_fit_q, best_fit_d;
  logic             busy_q, busy_d;
  logic             eval_done_q, eval_done_d;

`ifdef FITNESS_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pop_rd_addr_d = pop_rd_addr_q;
    calc_start_d  = 1'b0;
    chrom_d       = chrom_q;
    fit_wr_en_d   = 1'b0;
    fit_wr_addr_d = fit_wr_addr_q;
    fit_wr_data_d = fit_wr_data_q;
    best_idx_d    = best_idx_q;
    best_fit_d    = best_fit_q;
    eval_done_d   = 1'b0;
`ifdef FITNESS_SCHED_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (eval_start) begin
          idx_d         = '0;
          pop_rd_addr_d = '0;
          best_fit_d    = FIT_WORST;
          best_idx_d    = '0;
`ifdef FITNESS_SCHED_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        chrom_d      = bus.pop_rd_data;
        calc_start_d = 1'b1;
        state_d      = S_START;
      end
      S_START: begin
`ifdef FITNESS_SCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.calc_done) begin
          fit_wr_en_d   = 1'b1;
          fit_wr_addr_d = idx_q;
          fit_wr_data_d = bus.calc_fitness;
          state_d       = S_STORE;
        end
`ifdef FITNESS_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Calculator never answered: record the worst fitness and move on.
          fit_wr_en_d   = 1'b1;
          fit_wr_addr_d = idx_q;
          fit_wr_data_d = FIT_WORST;
          timeout_err_d = 1'b1;
          state_d       = S_STORE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      S_STORE: begin
        // Strict compare keeps the lower index on ties.
        if (fit_wr_data_q < best_fit_q) begin
          best_fit_d = fit_wr_data_q;
          best_idx_d = fit_wr_addr_q;
        end
        if (idx_q == IDX_W'(POP_SIZE - 1)) begin
          eval_done_d = 1'b1;
          state_d     = S_FINISH;
        end else begin
          idx_d         = idx_q + IDX_W'(1);
          pop_rd_addr_d = idx_q + IDX_W'(1);
          state_d       = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      pop_rd_addr_q <= '0;
      calc_start_q  <= 1'b0;
      for (int i = 0; i < int'(GENOME_LENGTH); i++) chrom_q[i] <= '0;
      fit_wr_en_q   <= 1'b0;
      fit_wr_addr_q <= '0;
      fit_wr_data_q <= '0;
      best_idx_q    <= '0;
      best_fit_q    <= FIT_WORST;
      busy_q        <= 1'b0;
      eval_done_q   <= 1'b0;
`ifdef FITNESS_SCHED_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pop_rd_addr_q <= pop_rd_addr_d;
      calc_start_q  <= calc_start_d;
      chrom_q       <= chrom_d;
      fit_wr_en_q   <= fit_wr_en_d;
      fit_wr_addr_q <= fit_wr_addr_d;
      fit_wr_data_q <= fit_wr_data_d;
      best_idx_q    <= best_idx_d;
      best_fit_q    <= best_fit_d;
      busy_q        <= busy_d;
      eval_done_q   <= eval_done_d;
`ifdef FITNESS_SCHED_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.pop_rd_addr     = pop_rd_addr_q;
  assign bus.calc_start      = calc_start_q;
  assign bus.calc_chromosome = chrom_q;
  assign bus.fit_wr_en       = fit_wr_en_q;
  assign bus.fit_wr_addr     = fit_wr_addr_q;
  assign bus.fit_wr_data     = fit_wr_data_q;
  assign best_idx            = best_idx_q;
  assign best_fitness        = best_fit_q;
  assign busy                = busy_q;
  assign eval_done           = eval_done_q;
`ifdef FITNESS_SCHED_TIMEOUT_EN
  assign timeout_err         = timeout_err_q;
`else
  assign timeout_err         = 1'b0;
`endif

endmodule
